sgd_x_host_wr: RTL

- Downstream consumer of the model-writeback handshake issued by the x write-control stage (writing_x_to_host_memory_en / writing_x_to_host_memory_done).
- When en is asserted, it streams the current model x out of the x BRAM read port and packs pairs of BRAM words into host cache lines.
- It issues those lines as memory write requests with valid/ready backpressure, then pulses done once the last line has been accepted.

---
 rtl/sgd_x_host_wr_pkg.sv | 17 +
 rtl/sgd_x_host_wr_fifo.sv | 52 +++++
 rtl/sgd_x_host_wr.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sgd_x_host_wr_pkg.sv
// Shared definitions for the x host-writeback path: FSM encoding, line size and
// the BRAM geometry defaults also used by the x write-control stage.
package sgd_x_host_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } xwr_state_e;

    localparam int LINE_BYTES        = 64;
    localparam int BANK_SHIFT_DFLT   = 3;
    localparam int X_ADDR_WIDTH_DFLT = 9;

endpackage

// File: rtl/sgd_x_host_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, used to stage
// packed host lines between the BRAM read pipeline and the write interface.
module sgd_x_host_wr_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop_ok)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sgd_x_host_wr.sv
// Streams model x from the x BRAM into 512-bit host lines and writes them out.
// Optional macro SGD_X_HOST_WR_EPOCH_OFFSET_EN places each epoch's model at its own offset.
module sgd_x_host_wr
    import sgd_x_host_wr_pkg::*;
#(
    parameter int X_DATA_WIDTH   = 256,
    parameter int MEM_DATA_WIDTH = 512,
    parameter int X_ADDR_WIDTH   = X_ADDR_WIDTH_DFLT,
    parameter int BANK_SHIFT     = BANK_SHIFT_DFLT,
    parameter int RD_LATENCY     = 2,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      started,
    input  logic [31:0]               dimension,
    input  logic [63:0]               addr_model,
    input  logic                      writing_x_to_host_memory_en,
    output logic                      writing_x_to_host_memory_done,
    output logic                      x_rd_en,
    output logic [X_ADDR_WIDTH-1:0]   x_rd_addr,
    input  logic [X_DATA_WIDTH-1:0]   x_rd_data,
    output logic                      um_tx_wr_valid,
    input  logic                      um_tx_wr_ready,
    output logic [63:0]               um_tx_wr_addr,
    output logic [MEM_DATA_WIDTH-1:0] um_tx_data,
    output logic [31:0]               state_counters_x_host_wr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    xwr_state_e state_q, state_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [31:0] line_idx_q, line_idx_d;
    logic [63:0] base_q, base_d, base_new;
    logic [7:0]  epoch_q, epoch_d;
    logic        started_q;
    logic [31:0] num_words_q, num_lines_q, num_words_new;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_odd_q, tag_last_q;
    logic [31:0]           inflight_lines;
    logic                  rd_last;

    logic [X_DATA_WIDTH-1:0]   lo_q;
    logic                      fifo_push, fifo_pop;
    logic [MEM_DATA_WIDTH-1:0] fifo_din, fifo_head;
    logic [CNT_W-1:0]          fifo_count;

    assign num_words_new = {{BANK_SHIFT{1'b0}}, dimension[31:BANK_SHIFT]}
                         + {31'b0, (dimension[BANK_SHIFT-1:0] != '0)};

`ifdef SGD_X_HOST_WR_EPOCH_OFFSET_EN
    logic [63:0] epoch_prod;
    assign epoch_prod = 64'(epoch_q) * 64'(num_lines_q);
    assign base_new   = addr_model + (epoch_prod << 6);
`else
    assign base_new = addr_model;
`endif

    assign rd_last = (word_idx_q == num_words_q - 32'd1);

    // Lines still owed to the FIFO by reads already issued to the BRAM.
    always_comb begin
        inflight_lines = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight_lines = inflight_lines + {31'b0, tag_vld_q[i] & (tag_odd_q[i] | tag_last_q[i])};
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        line_idx_d = line_idx_q + {31'b0, fifo_pop};
        base_d     = base_q;
        epoch_d    = epoch_q;
        x_rd_en    = 1'b0;
        writing_x_to_host_memory_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (writing_x_to_host_memory_en) begin
                    word_idx_d = '0;
                    line_idx_d = '0;
                    base_d     = base_new;
                    state_d    = (num_words_q == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (({{(32-CNT_W){1'b0}}, fifo_count} + inflight_lines) < 32'(FIFO_DEPTH)) begin
                    x_rd_en    = 1'b1;
                    word_idx_d = word_idx_q + 32'd1;
                    if (rd_last)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == '0 && tag_vld_q == '0 && line_idx_q == num_lines_q)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                writing_x_to_host_memory_done = 1'b1;
                epoch_d = epoch_q + 8'd1;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!writing_x_to_host_memory_en)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (started && !started_q)
            epoch_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= '0;
            line_idx_q  <= '0;
            base_q      <= '0;
            epoch_q     <= '0;
            started_q   <= 1'b0;
            num_words_q <= '0;
            num_lines_q <= '0;
            tag_vld_q   <= '0;
            tag_odd_q   <= '0;
            tag_last_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            line_idx_q  <= line_idx_d;
            base_q      <= base_d;
            epoch_q     <= epoch_d;
            started_q   <= started;
            num_words_q <= num_words_new;
            num_lines_q <= (num_words_q + 32'd1) >> 1;
            tag_vld_q[0]  <= x_rd_en;
            tag_odd_q[0]  <= word_idx_q[0];
            tag_last_q[0] <= rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_odd_q[i]  <= tag_odd_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    // Even word waits in lo_q for its odd partner; a trailing even word goes out alone.
    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = {x_rd_data, lo_q};
        if (tag_vld_q[RD_LATENCY-1]) begin
            if (tag_odd_q[RD_LATENCY-1]) begin
                fifo_push = 1'b1;
            end else if (tag_last_q[RD_LATENCY-1]) begin
                fifo_push = 1'b1;
                fifo_din  = {{X_DATA_WIDTH{1'b0}}, x_rd_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_vld_q[RD_LATENCY-1] && !tag_odd_q[RD_LATENCY-1])
            lo_q <= x_rd_data;
    end

    sgd_x_host_wr_fifo #(
        .WIDTH (MEM_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign um_tx_wr_valid = (fifo_count != '0);
    assign fifo_pop       = um_tx_wr_valid && um_tx_wr_ready;
    assign um_tx_data     = um_tx_wr_valid ? fifo_head : '0;
    assign um_tx_wr_addr  = base_q + {26'b0, line_idx_q, 6'b0};
    assign x_rd_addr      = word_idx_q[X_ADDR_WIDTH-1:0];
    assign state_counters_x_host_wr = {writing_x_to_host_memory_en, state_q,
                                       line_idx_q[19:0], epoch_q};

endmodule
